// File: rtl/aes_key_scheduler_if.sv
// Key-scheduler bus: key load handshake, round-key read port and status flags.
// The master side offers keys and round indices; the slave side is the scheduler.
interface aes_key_scheduler_if #(
  parameter int NK = 4
);
  logic              i_key_valid;
  logic              o_key_ready;
  logic [32*NK-1:0]  i_cypher_key;
  logic [3:0]        i_round_idx;
  logic [127:0]      o_round_key;
  logic              o_keys_valid;
  logic              o_busy;

  modport master (
    output i_key_valid, i_cypher_key, i_round_idx,
    input  o_key_ready, o_round_key, o_keys_valid, o_busy
  );

  modport slave (
    input  i_key_valid, i_cypher_key, i_round_idx,
    output o_key_ready, o_round_key, o_keys_valid, o_busy
  );
endinterface

// File: rtl/aes_key_scheduler.sv
// Iterative AES key expansion: one 32-bit word per clock through a single shared
// SubWord unit, results held in a word array and read out as registered round keys.
module aes_key_scheduler #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  aes_key_scheduler_if.slave  kif
);

  localparam int NW = 4 * (NR + 1);
  localparam int CW = $clog2(NW);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t          state_q, state_d;
  logic [31:0]     w [NW];
  logic [CW-1:0]   wcnt;
  logic [2:0]      kidx;
  logic [7:0]      rcon;
  logic            keys_valid;
  logic [127:0]    round_key;
  logic            key_ready;
  logic            busy;
  logic            accept;
  logic            last_word;
  logic [31:0]     prev_word;
  logic [31:0]     sub_in;
  logic [31:0]     sub_out;
  logic [31:0]     temp;
  logic [31:0]     new_word;
  logic [3:0]      rsel;
  logic [CW-1:0]   rbase;
  logic            rd_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    key_ready = 1'b1;
    busy      = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = EXPAND;
      EXPAND: begin
        key_ready = 1'b0;
        busy      = 1'b1;
        if (last_word) state_d = DONE;
      end
      DONE:    if (accept) state_d = EXPAND;
      default: state_d = IDLE;
    endcase
  end

  assign accept    = kif.i_key_valid && (state_q != EXPAND);
  assign last_word = (state_q == EXPAND) && (wcnt == CW'(NW - 1));

  // kidx tracks i mod NK so NK=6 needs no divider.
  always_comb begin
    prev_word = w[wcnt - CW'(1)];
    sub_in    = (kidx == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sub_out   = sub_word(sub_in);
    if (kidx == 3'd0)                temp = sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && kidx == 3'd4) temp = sub_out;
    else                             temp = prev_word;
    new_word  = w[wcnt - CW'(NK)] ^ temp;
  end

  assign rd_ok = keys_valid && (kif.i_round_idx <= 4'(NR));
  assign rsel  = rd_ok ? kif.i_round_idx : 4'd0;
  assign rbase = CW'({rsel, 2'b00});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wcnt       <= '0;
      kidx       <= '0;
      rcon       <= 8'h01;
      keys_valid <= 1'b0;
      round_key  <= '0;
    end else begin
      if (accept) begin
        wcnt       <= CW'(NK);
        kidx       <= '0;
        rcon       <= 8'h01;
        keys_valid <= 1'b0;
      end else if (state_q == EXPAND) begin
        wcnt <= wcnt + CW'(1);
        kidx <= (kidx == 3'(NK - 1)) ? 3'd0 : kidx + 3'd1;
        if (kidx == 3'd0) rcon <= xtime(rcon);
        if (last_word) keys_valid <= 1'b1;
      end
      round_key <= rd_ok ? {w[rbase], w[rbase + CW'(1)], w[rbase + CW'(2)], w[rbase + CW'(3)]}
                         : '0;
    end
  end

  // Word storage carries no reset; validity is tracked by keys_valid alone.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int k = 0; k < NK; k++) w[k] <= kif.i_cypher_key[32*(NK-1-k) +: 32];
    end else if (state_q == EXPAND) begin
      w[wcnt] <= new_word;
    end
  end

  assign kif.o_key_ready  = key_ready;
  assign kif.o_busy       = busy;
  assign kif.o_keys_valid = keys_valid;
  assign kif.o_round_key  = round_key;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Bench for aes_key_scheduler: NK=4 and NK=8 instances checked against FIPS-197
// vectors and a reference expansion whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_scheduler;

  localparam logic [127:0] K4    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K4_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K4_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K8    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K8_R1 = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K8_RE = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  logic rst4_n = 1'b0;
  logic rst8_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [7:0]  ref_sbox [256];
  logic [31:0] ref_w [60];

  always #5 clk = ~clk;

  aes_key_scheduler_if #(.NK(4)) if4 ();
  aes_key_scheduler_if #(.NK(8)) if8 ();

  aes_key_scheduler #(.NK(4), .NR(10)) u4 (.i_clk(clk), .i_rst_n(rst4_n), .kif(if4.slave));
  aes_key_scheduler #(.NK(8), .NR(14)) u8 (.i_clk(clk), .i_rst_n(rst8_n), .kif(if8.slave));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      ref_sbox[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
  endfunction

  task automatic ref_expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) ref_w[i] = key[32*(nk-1-i) +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic acc4(input logic [127:0] key);
    @(negedge clk); if4.i_key_valid = 1'b1; if4.i_cypher_key = key;
    @(posedge clk); #1; if4.i_key_valid = 1'b0;
  endtask

  task automatic acc8(input logic [255:0] key);
    @(negedge clk); if8.i_key_valid = 1'b1; if8.i_cypher_key = key;
    @(posedge clk); #1; if8.i_key_valid = 1'b0;
  endtask

  task automatic wait4(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!if4.o_keys_valid && n < 200);
  endtask

  task automatic wait8(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!if8.o_keys_valid && n < 200);
  endtask

  task automatic rd4(input int idx, output logic [127:0] rk);
    @(negedge clk); if4.i_round_idx = 4'(idx);
    @(posedge clk); #1; rk = if4.o_round_key;
  endtask

  task automatic rd8(input int idx, output logic [127:0] rk);
    @(negedge clk); if8.i_round_idx = 4'(idx);
    @(posedge clk); #1; rk = if8.o_round_key;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt += 8;
    if (if4.o_key_ready !== 1'b1) $display("FAIL rst4_ready: got %b want 1", if4.o_key_ready); else pass_cnt++;
    if (if4.o_busy !== 1'b0) $display("FAIL rst4_busy: got %b want 0", if4.o_busy); else pass_cnt++;
    if (if4.o_keys_valid !== 1'b0) $display("FAIL rst4_kv: got %b want 0", if4.o_keys_valid); else pass_cnt++;
    if (if4.o_round_key !== 128'h0) $display("FAIL rst4_rk: got %h want 0", if4.o_round_key); else pass_cnt++;
    if (if8.o_key_ready !== 1'b1) $display("FAIL rst8_ready: got %b want 1", if8.o_key_ready); else pass_cnt++;
    if (if8.o_busy !== 1'b0) $display("FAIL rst8_busy: got %b want 0", if8.o_busy); else pass_cnt++;
    if (if8.o_keys_valid !== 1'b0) $display("FAIL rst8_kv: got %b want 0", if8.o_keys_valid); else pass_cnt++;
    if (if8.o_round_key !== 128'h0) $display("FAIL rst8_rk: got %h want 0", if8.o_round_key); else pass_cnt++;
    rst4_n = 1'b1; rst8_n = 1'b1;
  endtask

  task automatic test_nk4_kat();
    int n; logic [127:0] rk;
    acc4(K4);
    total_cnt += 3;
    if (if4.o_keys_valid !== 1'b0) $display("FAIL kat4_kv_low: got %b want 0", if4.o_keys_valid); else pass_cnt++;
    if (if4.o_busy !== 1'b1) $display("FAIL kat4_busy: got %b want 1", if4.o_busy); else pass_cnt++;
    if (if4.o_key_ready !== 1'b0) $display("FAIL kat4_ready: got %b want 0", if4.o_key_ready); else pass_cnt++;
    wait4(n);
    total_cnt += 3;
    if (n !== 40) $display("FAIL kat4_latency: got %0d want 40", n); else pass_cnt++;
    if (if4.o_busy !== 1'b0) $display("FAIL kat4_busy_done: got %b want 0", if4.o_busy); else pass_cnt++;
    if (if4.o_key_ready !== 1'b1) $display("FAIL kat4_ready_done: got %b want 1", if4.o_key_ready); else pass_cnt++;
    rd4(1, rk);
    total_cnt++; if (rk !== K4_R1) $display("FAIL kat4_idx1: got %h want %h", rk, K4_R1); else pass_cnt++;
    rd4(10, rk);
    total_cnt++; if (rk !== K4_RA) $display("FAIL kat4_idx10: got %h want %h", rk, K4_RA); else pass_cnt++;
    ref_expand({128'h0, K4}, 4, 10);
    for (int r = 0; r <= 10; r++) begin
      rd4(r, rk);
      total_cnt++;
      if (rk !== {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]})
        $display("FAIL kat4_rk%0d: got %h want %h", r, rk, {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]});
      else pass_cnt++;
    end
  endtask

  task automatic test_nk8_kat();
    int n; logic [127:0] rk;
    acc8(K8);
    wait8(n);
    total_cnt++; if (n !== 52) $display("FAIL kat8_latency: got %0d want 52", n); else pass_cnt++;
    rd8(1, rk);
    total_cnt++; if (rk !== K8_R1) $display("FAIL kat8_idx1: got %h want %h", rk, K8_R1); else pass_cnt++;
    rd8(14, rk);
    total_cnt++; if (rk !== K8_RE) $display("FAIL kat8_idx14: got %h want %h", rk, K8_RE); else pass_cnt++;
    ref_expand(K8, 8, 14);
    for (int r = 0; r <= 14; r++) begin
      rd8(r, rk);
      total_cnt++;
      if (rk !== {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]})
        $display("FAIL kat8_rk%0d: got %h want %h", r, rk, {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]});
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_during_expand();
    int n; logic [127:0] rk;
    acc4(K4);
    repeat (9) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (if4.o_key_ready !== 1'b0) $display("FAIL ign_ready: got %b want 0", if4.o_key_ready); else pass_cnt++;
    if4.i_key_valid = 1'b1; if4.i_cypher_key = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge clk); #1; if4.i_key_valid = 1'b0;
    total_cnt++; if (if4.o_busy !== 1'b1) $display("FAIL ign_busy: got %b want 1", if4.o_busy); else pass_cnt++;
    wait4(n);
    total_cnt++; if (n + 10 !== 40) $display("FAIL ign_latency: got %0d want 40", n + 10); else pass_cnt++;
    rd4(1, rk);
    total_cnt++; if (rk !== K4_R1) $display("FAIL ign_idx1: got %h want %h", rk, K4_R1); else pass_cnt++;
    rd4(10, rk);
    total_cnt++; if (rk !== K4_RA) $display("FAIL ign_idx10: got %h want %h", rk, K4_RA); else pass_cnt++;
  endtask

  task automatic test_reset_mid_expand();
    int n; logic [127:0] rk;
    acc4(K4);
    repeat (20) @(posedge clk);
    #3; rst4_n = 1'b0; #1;
    total_cnt += 4;
    if (if4.o_busy !== 1'b0) $display("FAIL rstm_busy: got %b want 0", if4.o_busy); else pass_cnt++;
    if (if4.o_keys_valid !== 1'b0) $display("FAIL rstm_kv: got %b want 0", if4.o_keys_valid); else pass_cnt++;
    if (if4.o_round_key !== 128'h0) $display("FAIL rstm_rk: got %h want 0", if4.o_round_key); else pass_cnt++;
    if (if4.o_key_ready !== 1'b1) $display("FAIL rstm_ready: got %b want 1", if4.o_key_ready); else pass_cnt++;
    @(negedge clk); rst4_n = 1'b1;
    rd4(1, rk);
    total_cnt += 2;
    if (rk !== 128'h0) $display("FAIL rstm_rk_after: got %h want 0", rk); else pass_cnt++;
    if (if4.o_keys_valid !== 1'b0) $display("FAIL rstm_kv_after: got %b want 0", if4.o_keys_valid); else pass_cnt++;
    acc4(K4);
    wait4(n);
    total_cnt++; if (n !== 40) $display("FAIL rstm_latency: got %0d want 40", n); else pass_cnt++;
    rd4(1, rk);
    total_cnt++; if (rk !== K4_R1) $display("FAIL rstm_idx1: got %h want %h", rk, K4_R1); else pass_cnt++;
    rd4(10, rk);
    total_cnt++; if (rk !== K4_RA) $display("FAIL rstm_idx10: got %h want %h", rk, K4_RA); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    int n; logic [127:0] rk, key;
    rd4(10, rk);
    total_cnt++; if (rk !== K4_RA) $display("FAIL oor_idx10: got %h want %h", rk, K4_RA); else pass_cnt++;
    rd4(11, rk);
    total_cnt++; if (rk !== 128'h0) $display("FAIL oor_idx11: got %h want 0", rk); else pass_cnt++;
    rd4(9, rk);
    rd4(15, rk);
    total_cnt++; if (rk !== 128'h0) $display("FAIL oor_idx15: got %h want 0", rk); else pass_cnt++;
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    acc4(key);
    total_cnt++; if (if4.o_keys_valid !== 1'b0) $display("FAIL redo_kv_low: got %b want 0", if4.o_keys_valid); else pass_cnt++;
    wait4(n);
    total_cnt++; if (n !== 40) $display("FAIL redo_latency: got %0d want 40", n); else pass_cnt++;
    ref_expand({128'h0, key}, 4, 10);
    for (int r = 0; r <= 10; r++) begin
      rd4(r, rk);
      total_cnt++;
      if (rk !== {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]})
        $display("FAIL redo_rk%0d: got %h want %h", r, rk, {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]});
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int n; logic [127:0] rk, k4; logic [255:0] k8;
    for (int t = 0; t < 3; t++) begin
      k4 = {$urandom(), $urandom(), $urandom(), $urandom()};
      acc4(k4);
      wait4(n);
      total_cnt++; if (n !== 40) $display("FAIL b2b4_latency%0d: got %0d want 40", t, n); else pass_cnt++;
      ref_expand({128'h0, k4}, 4, 10);
      for (int r = 0; r <= 10; r++) begin
        rd4(r, rk);
        total_cnt++;
        if (rk !== {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]})
          $display("FAIL b2b4_rk%0d: got %h want %h", r, rk, {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]});
        else pass_cnt++;
      end
    end
    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < 8; j++) k8[32*j +: 32] = $urandom();
      acc8(k8);
      wait8(n);
      total_cnt++; if (n !== 52) $display("FAIL b2b8_latency%0d: got %0d want 52", t, n); else pass_cnt++;
      ref_expand(k8, 8, 14);
      for (int r = 0; r <= 14; r++) begin
        rd8(r, rk);
        total_cnt++;
        if (rk !== {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]})
          $display("FAIL b2b8_rk%0d: got %h want %h", r, rk, {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]});
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    if4.i_key_valid = 1'b0; if4.i_cypher_key = '0; if4.i_round_idx = '0;
    if8.i_key_valid = 1'b0; if8.i_cypher_key = '0; if8.i_round_idx = '0;
    build_sbox();
    test_reset();
    test_nk4_kat();
    test_nk8_kat();
    test_ignore_during_expand();
    test_reset_mid_expand();
    test_out_of_range();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/aes_key_scheduler.md
AES_KEY_SCHEDULER -- requirements
Module: aes_key_scheduler

Interface
REQ-001 SHALL have parameter NK, default 4: key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 SHALL have parameter NR, default 10: number of rounds; legal values are 10, 12 and 14, paired with NK as 4/10, 6/12, 8/14.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_key_valid, input, 1 bit: a cypher key is offered.
REQ-006 SHALL have port o_key_ready, output, 1 bit: the scheduler can accept a key.
REQ-007 SHALL have port i_cypher_key, input, 32*NK bits: the key; the MSB word is w[0].
REQ-008 SHALL have port i_round_idx, input, 4 bits: index of the requested round key.
REQ-009 SHALL have port o_round_key, output, 128 bits: the selected round key, registered.
REQ-010 SHALL have port o_keys_valid, output, 1 bit: all round keys of the current key are available.
REQ-011 SHALL have port o_busy, output, 1 bit: expansion in progress.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, EXPAND, DONE.
REQ-013 SHALL drive o_key_ready=1 in IDLE and DONE, and 0 in EXPAND; o_busy SHALL be 1 only in EXPAND.
REQ-014 SHALL accept a key on any rising edge with i_key_valid && o_key_ready; on that edge it SHALL store w[0..NK-1], set word counter=NK, set rcon=0x01, clear o_keys_valid and enter EXPAND.
REQ-015 SHALL, in EXPAND, compute and store exactly one word w[i] per clock for i=NK..4*(NR+1)-1, using one shared 4-byte SubWord unit built from the existing S-box.
REQ-016 SHALL compute the word as follows: temp=w[i-1]; if i mod NK==0, temp=SubWord(RotWord(temp)) xor {rcon,24'h0} and then rcon=xtime(rcon), where 0x80 becomes 0x1b; else if NK==8 and i mod NK==4, temp=SubWord(temp); w[i]=w[i-NK] xor temp.
REQ-017 SHALL, on the edge that writes w[4*NR+3], enter DONE and set o_keys_valid=1; o_keys_valid therefore rises 4*(NR+1)-NK edges after acceptance: 40, 46 or 52.
REQ-018 SHALL ignore i_key_valid while in EXPAND, with no effect on state or storage.
REQ-019 SHALL, on a key accepted in DONE, drop o_keys_valid on the acceptance edge and restart expansion; old round keys are then invalid.
REQ-020 SHALL register o_round_key each edge as {w[4r],w[4r+1],w[4r+2],w[4r+3]} with r=i_round_idx when o_keys_valid=1 and r<=NR, and as 0 otherwise; read latency is 1 clock.
REQ-021 SHALL hold storage unchanged in DONE; i_cypher_key is sampled only on the acceptance edge.
REQ-022 SHALL store the expanded words in a register array of 4*(NR+1) entries of 32 bits each.

Reset
REQ-023 SHALL, while i_rst_n=0, force the FSM to IDLE, the word counter to 0, rcon to 0x01, o_keys_valid=0, o_busy=0, o_round_key=0 and o_key_ready=1, independent of i_clk.
REQ-024 SHALL treat reset during EXPAND as aborting the expansion; after release, no round key is valid until a new key completes expansion.
REQ-025 SHALL NOT require the word storage to be cleared by reset.

Verification
REQ-026 The bench SHALL load NK=4 key 2b7e151628aed2a6abf7158809cf4f3c, then wait for o_keys_valid -> it rises exactly 40 edges after acceptance; idx 1 -> a0fafe1788542cb123a339392a6c7605; idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-027 The bench SHALL load NK=8 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> o_keys_valid after 52 edges; idx 1 -> 1f352c073b6108d72d9810a30914dff4; idx 14 -> fe4890d1e6188d0b046df344706c631e.
REQ-028 The bench SHALL pulse i_key_valid with a different key at edge 10 of an NK=4 expansion -> o_key_ready=0, the pulse is ignored, and the result equals REQ-026.
REQ-029 The bench SHALL assert i_rst_n=0 at edge 20 of an NK=4 expansion -> o_busy=0, o_keys_valid=0 and o_round_key=0 immediately; reloading the REQ-026 key then gives the REQ-026 results.
REQ-030 The bench SHALL request idx 11 and idx 15 with NK=4 in DONE -> o_round_key=0 one clock later; a new key accepted in DONE -> o_keys_valid=0 on that edge and high again 40 edges later.
REQ-031 The bench SHALL compare all round keys 0..NR against the FIPS-197 expansion for NK=4 and NK=8 -> every round key matches.
